sti_rx_packer: RTL

STI_RX_PACKER -- requirements
Module: sti_rx_packer

---
 rtl/sti_pkg.sv | 17 +
 rtl/sti_rx_packer_if.sv | 13 +
 rtl/sti_rx_fifo.sv | 82 ++++++++
 rtl/sti_rx_packer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared definitions for the serial-to-byte receive path.
package sti_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } sti_state_e;

  // Byte position written by the idx-th bit of a byte for the given bit order.
  function automatic logic [2:0] bit_pos(input logic msb, input logic [2:0] idx);
    return msb ? (3'd7 - idx) : idx;
  endfunction

endpackage

// File: rtl/sti_rx_packer_if.sv
// Byte stream handshake between the receive FIFO and its consumer.
interface sti_rx_packer_if;
  import sti_pkg::*;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_last;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_data, output byte_last, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_last, input byte_valid, output byte_ready);

endinterface

// File: rtl/sti_rx_fifo.sv
// First-word-fall-through FIFO of {last,data} entries; drops pushes when full.
module sti_rx_fifo
  import sti_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [BYTE_W:0]       wdata,
  output logic                  overflow,
  sti_rx_packer_if.master       bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W:0] mem_q [DEPTH];
  logic [BYTE_W:0] mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  logic            overflow_q, overflow_d;
  logic            pop_s, full_s, wr_en_s;

  // Next-state for storage, pointers, occupancy and the sticky drop flag.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pop_s      = valid_q & bus.byte_ready;
    full_s     = (count_q == CW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    wr_en_s    = push & (~full_s | pop_s);
    overflow_d = overflow_q | (push & ~wr_en_s);
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != CW'(0));
  end

  // Register FIFO state; synchronous reset empties it and clears the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.byte_data  = mem_q[rd_ptr_q][BYTE_W-1:0];
  assign bus.byte_last  = mem_q[rd_ptr_q][BYTE_W];
  assign bus.byte_valid = valid_q;
  assign overflow       = overflow_q;

endmodule

// File: rtl/sti_rx_packer.sv
// Packs framed serial bits into bytes and queues them with an end-of-frame flag.
module sti_rx_packer
  import sti_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic              si_msb,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic [7:0]        frame_cnt
);

  sti_state_e        state_q;
  logic              resumed_q;
  logic              msb_q, msb_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] sr_q, sr_d;
  logic [BYTE_W-1:0] stage_q, stage_d;
  logic              stage_vld_q, stage_vld_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              in_frame_s, first_s, msb_eff_s;
  logic [2:0]        cnt_cur_s;
  logic [BYTE_W-1:0] byte_new_s;
  logic              push_s;
  logic [BYTE_W:0]   push_data_s;

  sti_rx_packer_if u_bus ();

  // Frame tracking FSM; resumed_q covers a frame whose first bit lands in FLUSH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      resumed_q <= 1'b0;
    end else begin
      resumed_q <= (state_q == FLUSH) & si_valid;
      case (state_q)
        IDLE:    state_q <= si_valid ? SHIFT : IDLE;
        SHIFT:   state_q <= si_valid ? SHIFT : FLUSH;
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bit packing, staging and push generation for full and partial bytes.
  always_comb begin
    in_frame_s  = (state_q == SHIFT) | resumed_q;
    first_s     = si_valid & ~in_frame_s;
    msb_eff_s   = first_s ? si_msb : msb_q;
    cnt_cur_s   = first_s ? 3'd0 : cnt_q;
    // A fresh byte starts from zero so unfilled positions read as padding.
    byte_new_s  = (cnt_cur_s == 3'd0) ? {BYTE_W{1'b0}} : sr_q;
    byte_new_s[bit_pos(msb_eff_s, cnt_cur_s)] = si_data;

    msb_d       = msb_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    stage_d     = stage_q;
    stage_vld_d = 1'b0;
    frame_err_d = 1'b0;
    push_s      = 1'b0;
    push_data_s = {(BYTE_W+1){1'b0}};

    if (si_valid) begin
      msb_d = msb_eff_s;
      if (cnt_cur_s == 3'd7) begin
        stage_d     = byte_new_s;
        stage_vld_d = 1'b1;
        cnt_d       = 3'd0;
      end else begin
        sr_d  = byte_new_s;
        cnt_d = cnt_cur_s + 3'd1;
      end
    end else begin
      cnt_d = 3'd0;
    end

    // A staged byte and a partial byte can never be due on the same edge.
    if (stage_vld_q) begin
      push_s      = 1'b1;
      push_data_s = {~si_valid, stage_q};
    end else if (~si_valid & in_frame_s & (cnt_q != 3'd0)) begin
      push_s      = 1'b1;
      push_data_s = {1'b1, sr_q};
      frame_err_d = 1'b1;
    end else begin
      push_s = 1'b0;
    end

    frame_cnt_d = frame_cnt_q + ((push_s & push_data_s[BYTE_W]) ? 8'd1 : 8'd0);
  end

  // Register the packing datapath and the status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      msb_q       <= 1'b0;
      cnt_q       <= 3'd0;
      sr_q        <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      msb_q       <= msb_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  sti_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .wdata    (push_data_s),
    .overflow (overflow),
    .bus      (u_bus.master)
  );

  assign u_bus.byte_ready = byte_ready;
  assign byte_data        = u_bus.byte_data;
  assign byte_last        = u_bus.byte_last;
  assign byte_valid       = u_bus.byte_valid;
  assign frame_err        = frame_err_q;
  assign frame_cnt        = frame_cnt_q;

endmodule
